// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned MAX_WAIT_DEF = 15;
endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive imem not-ready cycles; expire flags the cycle that would reach MAX_WAIT.
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [7:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clr) count <= 8'd0;
    else if (inc)   count <= count + 8'd1;
  end

  // Combinational so the fetch FSM can time out on the same edge the count would reach MAX_WAIT.
  assign expire = inc && (count == 8'(MAX_WAIT - 1));
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem requests and presents words/bubbles to IF/ID.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] InstWord_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus4_F,
  output logic        nop_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [31:0] fetch_cnt_o,
  output logic [1:0]  state_o
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_d, timeout_d;
  logic [31:0]  fetch_cnt_d;
  logic         wt_clr, wt_inc, wt_expire;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (wt_clr),
    .inc    (wt_inc),
    .expire (wt_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
      fetch_cnt_o <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      misalign_o  <= misalign_d;
      timeout_o   <= timeout_d;
      fetch_cnt_o <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_o;
    timeout_d   = timeout_o;
    fetch_cnt_d = fetch_cnt_o;
    wt_clr      = 1'b0;
    wt_inc      = 1'b0;
    imem_req_o  = 1'b0;
    nop_o       = 1'b1;
    InstWord_F  = NOP_INSN;
    halted_o    = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, WAIT: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          InstWord_F = imem_rdata_i;
          nop_o      = 1'b0;
        end
        // Redirect squashes the wrong-path word and outranks halt, stall and imem status.
        if (redirect_i) begin
          pc_d       = {redirect_pc_i[31:2], 2'b00};
          misalign_d = misalign_o | (|redirect_pc_i[1:0]);
          nop_o      = 1'b1;
          state_d    = FETCH;
          wt_clr     = 1'b1;
        end else if (halt_i) begin
          state_d = HALT;
        end else if (stall_i) begin
          nop_o = 1'b0;
        end else if (imem_ready_i) begin
          pc_d        = pc_q + 32'd4;
          state_d     = FETCH;
          wt_clr      = 1'b1;
          fetch_cnt_d = fetch_cnt_o + 32'd1;
        end else begin
          state_d = WAIT;
          wt_inc  = 1'b1;
          if (wt_expire) begin
            timeout_d = 1'b1;
            state_d   = HALT;
          end
        end
      end
      HALT: halted_o = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  assign imem_addr_o = pc_q;
  assign PC_F        = pc_q;
  assign PC_Plus4_F  = pc_q + 32'd4;
  assign state_o     = state_q;
endmodule
